// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial equality checker: FSM state
// encoding and the ceiling-log2 used to size the index and count registers.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to represent value distinct codes (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_match.sv
// Combinational equality of one serial bit pair.
module bit_match (
    input  logic a,
    input  logic b,
    output logic out
);

    assign out = (a == b);

endmodule

// File: rtl/serial_eq_checker.sv
// Compares two LSB-first serial words of WIDTH bits and reports equality.
// Define MISMATCH_CNT_EN to add the mismatch counter and the mism_cnt port.
module serial_eq_checker
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic eq
`ifdef MISMATCH_CNT_EN
    ,
    output logic [clog2(WIDTH + 1)-1:0] mism_cnt
`endif
);

    localparam int IW = (clog2(WIDTH) > 1) ? clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t          state_reg;
    logic [IW-1:0]   bit_idx_reg;
    logic            match_acc_reg;
    logic            match_next;
    logic            bit_eq;

`ifdef MISMATCH_CNT_EN
    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [CW-1:0]   cnt_acc_reg;
    logic [CW-1:0]   cnt_next;

    // Saturating increment; WIDTH mismatches is the natural ceiling.
    always_comb begin
        cnt_next = cnt_acc_reg;
        if (!bit_eq && (cnt_acc_reg != CNT_MAX)) begin
            cnt_next = cnt_acc_reg + CW'(1);
        end
    end
`endif

    bit_match u_bit_match (
        .a   (a_bit),
        .b   (b_bit),
        .out (bit_eq)
    );

    assign match_next = match_acc_reg & bit_eq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            eq            <= 1'b0;
            bit_idx_reg   <= '0;
            match_acc_reg <= 1'b0;
`ifdef MISMATCH_CNT_EN
            cnt_acc_reg   <= '0;
            mism_cnt      <= '0;
`endif
        end else begin
            case (state_reg)
                // DONE behaves like IDLE except it always leaves after one cycle.
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_reg     <= SHIFT;
                        busy          <= 1'b1;
                        bit_idx_reg   <= '0;
                        match_acc_reg <= 1'b1;
`ifdef MISMATCH_CNT_EN
                        cnt_acc_reg   <= '0;
`endif
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_valid) begin
                        match_acc_reg <= match_next;
`ifdef MISMATCH_CNT_EN
                        cnt_acc_reg   <= cnt_next;
`endif
                        if (bit_idx_reg == LAST_IDX) begin
                            state_reg <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            eq        <= match_next;
`ifdef MISMATCH_CNT_EN
                            mism_cnt  <= cnt_next;
`endif
                        end else begin
                            bit_idx_reg <= bit_idx_reg + IW'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_eq_checker.sv
// Randomized and directed bench for serial_eq_checker with a word-level
// reference model; works with or without MISMATCH_CNT_EN.
module tb_serial_eq_checker;
    import serial_cmp_pkg::*;

    localparam int W  = 8;
    localparam int CW = clog2(W + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic bit_valid = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic busy, done, eq;
`ifdef MISMATCH_CNT_EN
    logic [CW-1:0] mism_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;
    bit armed = 1'b0;

    serial_eq_checker #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .eq        (eq)
`ifdef MISMATCH_CNT_EN
        ,
        .mism_cnt  (mism_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic chk_cnt(input string name, input int exp);
`ifdef MISMATCH_CNT_EN
        chk(name, int'(mism_cnt), exp);
`endif
    endtask

    // Word-level reference: collect valid bit pairs, judge once WIDTH arrive.
    int         m_phase = 0;  // 0 waiting, 1 collecting, 2 result cycle
    int         m_nbits = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    bit         exp_busy = 0, exp_done = 0, exp_eq = 0;
    int         exp_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_nbits = 0;
            exp_busy = 0; exp_done = 0; exp_eq = 0; exp_cnt = 0;
        end else begin
            if (m_phase == 1) begin
                if (bit_valid) begin
                    m_a[m_nbits] = a_bit;
                    m_b[m_nbits] = b_bit;
                    m_nbits++;
                    if (m_nbits == W) begin
                        exp_eq   = (m_a == m_b);
                        exp_cnt  = $countones(m_a ^ m_b);
                        exp_done = 1;
                        m_phase  = 2;
                    end
                end
            end else begin
                exp_done = 0;
                if (start) begin
                    m_phase = 1; m_nbits = 0; m_a = '0; m_b = '0;
                end else begin
                    m_phase = 0;
                end
            end
            exp_busy = (m_phase == 1);
        end
    end

    always @(negedge clk) begin
        if (armed && rst_n) begin
            chk("cyc_busy", int'(busy), int'(exp_busy));
            chk("cyc_done", int'(done), int'(exp_done));
            chk("cyc_eq", int'(eq), int'(exp_eq));
            chk_cnt("cyc_cnt", exp_cnt);
        end
    end

    task automatic pair(input bit s, input bit v, input bit a, input bit b);
        @(negedge clk);
        #1;
        start = s; bit_valid = v; a_bit = a; b_bit = b;
    endtask

    // Sends one word; returns just after the negedge where done is visible.
    task automatic word(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit need_start, input bit gaps, input bit noise,
                        input bit rnd_valid, input bit hold);
        if (need_start) pair(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < W; i++) begin
            if (rnd_valid)
                while ($urandom_range(3) == 0)
                    pair(noise & 1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
            pair(noise & 1'($urandom), 1'b1, a[i], b[i]);
            if (gaps && (i == 1 || i == 6))
                repeat (3) pair(noise, 1'b0, 1'($urandom), 1'($urandom));
        end
        @(negedge clk);
        #1;
        start = hold; bit_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit b2b;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_eq", int'(eq), 0);
        chk_cnt("rst_cnt", 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        armed = 1'b1;
        repeat (2) @(negedge clk);

        word(8'hA5, 8'hA5, 1, 0, 0, 0, 0);
        chk("a5_done", int'(done), 1);
        chk("a5_busy", int'(busy), 0);
        chk("a5_eq", int'(eq), 1);
        chk_cnt("a5_cnt", 0);

        word(8'hFF, 8'h0F, 1, 0, 0, 0, 0);
        chk("ff0f_done", int'(done), 1);
        chk("ff0f_eq", int'(eq), 0);
        chk_cnt("ff0f_cnt", 4);
        repeat (3) @(negedge clk);
        #1;
        chk("hold_eq", int'(eq), 0);
        chk_cnt("hold_cnt", 4);
        chk("hold_done", int'(done), 0);

        word(8'h3C, 8'h3C, 1, 1, 1, 0, 0);
        chk("gap_done", int'(done), 1);
        chk("gap_eq", int'(eq), 1);

        word(8'h12, 8'h12, 1, 0, 0, 0, 1);
        chk("b2b1_eq", int'(eq), 1);
        @(negedge clk);
        #1;
        chk("b2b_busy", int'(busy), 1);
        start = 1'b0;
        word(8'h00, 8'h01, 0, 0, 0, 0, 0);
        chk("b2b2_done", int'(done), 1);
        chk("b2b2_eq", int'(eq), 0);
        chk_cnt("b2b2_cnt", 1);

        // Abort a word with reset between clock edges.
        pair(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pair(1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        start = 1'b0; bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_eq", int'(eq), 0);
        chk_cnt("arst_cnt", 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        word(8'h5A, 8'h5A, 1, 0, 0, 0, 0);
        chk("post_rst_eq", int'(eq), 1);
        chk("post_rst_done", int'(done), 1);

        b2b = 0;
        for (int n = 0; n < 60; n++) begin
            ra = W'($urandom);
            case ($urandom_range(2))
                0: rb = ra;
                1: rb = ra ^ W'(1 << $urandom_range(W - 1));
                default: rb = W'($urandom);
            endcase
            word(ra, rb, !b2b, 0, 1, 1, 0);
            b2b = 1'($urandom);
            start = b2b;
            if (!b2b) repeat ($urandom_range(2)) pair(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        pair(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        armed = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
